register_writeback: RTL and testbench

- Write-side producer for the 4x8 `register_file`. Collects results from the ALU (single-cycle) and the memory unit (load data) over valid/ready handshakes.
- Arbitrates between them and buffers results in a small FIFO.
- Drives the register file write port (`write_enable`, `dest_reg`, `write_data`), one write per cycle.
- Keeps a per-register busy scoreboard so decode can detect read-after-write hazards.

---
 rtl/register_writeback.sv | 120 ++++++++++++
 tb/tb_register_writeback.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/register_writeback.sv
// register_writeback: write-side producer for the register file.
//   Accepts ALU and load results over valid/ready handshakes. The memory unit
//   has fixed priority over the ALU. Results are buffered in a small FIFO and
//   presented to the register file write port one per cycle. A busy scoreboard
//   tracks pending destination writes for hazard detection in decode.
// Ports:
//   clk, reset        : clock, async active-low reset
//   issue_*           : decode issue (sets scoreboard bit)
//   busy, issue_err   : scoreboard, sticky double-issue flag
//   alu_*, mem_*      : result producers (valid/ready/dest/data)
//   hold              : write port owned elsewhere, suppresses writes
//   write_enable, dest_reg, write_data : register file write port
//   q_count           : entries queued, excluding the write-port stage
module register_writeback #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 2,
  localparam int NUM_REGS = 2**ADDR_W,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_dest,
  output logic [NUM_REGS-1:0] busy,
  output logic                issue_err,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [ADDR_W-1:0]   alu_dest,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [ADDR_W-1:0]   mem_dest,
  input  logic [DATA_W-1:0]   mem_data,
  input  logic                hold,
  output logic                write_enable,
  output logic [ADDR_W-1:0]   dest_reg,
  output logic [DATA_W-1:0]   write_data,
  output logic [CW-1:0]       q_count
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_t;

  wb_t           fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  wb_t           acc_item, head;
  logic          acc_mem, acc_alu, acc, fifo_empty;
  logic          push, pop, bypass;
  logic [NUM_REGS-1:0] busy_nxt;

  // Ready depends only on registered state (plus reset), never on hold.
  assign mem_ready = reset && (q_count < CW'(DEPTH));
  assign alu_ready = mem_ready && !mem_valid;

  always_comb begin
    acc_mem    = mem_valid && mem_ready;
    acc_alu    = alu_valid && alu_ready;
    acc        = acc_mem || acc_alu;
    acc_item.dest = acc_mem ? mem_dest : alu_dest;
    acc_item.data = acc_mem ? mem_data : alu_data;
    head       = fifo_q[rd_ptr];
    fifo_empty = (q_count == '0);
    pop        = !hold && !fifo_empty;
    // An accepted item skips the queue only when nothing is ahead of it
    // and the write port is free this cycle.
    bypass     = acc && !hold && fifo_empty;
    push       = acc && !bypass;
  end

  // Clear for the write being presented, then set; set wins on a collision.
  always_comb begin
    busy_nxt = busy;
    if (write_enable) busy_nxt[dest_reg] = 1'b0;
    if (issue_valid)  busy_nxt[issue_dest] = 1'b1;
  end

  // Queue storage carries no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= acc_item;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_enable <= 1'b0;
      dest_reg     <= '0;
      write_data   <= '0;
      busy         <= '0;
      issue_err    <= 1'b0;
      q_count      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   q_count <= q_count + CW'(1);
        2'b01:   q_count <= q_count - CW'(1);
        default: q_count <= q_count;
      endcase
      if (pop) begin
        write_enable <= 1'b1;
        dest_reg     <= head.dest;
        write_data   <= head.data;
      end else if (bypass) begin
        write_enable <= 1'b1;
        dest_reg     <= acc_item.dest;
        write_data   <= acc_item.data;
      end else begin
        // dest_reg/write_data keep their last values while idle or held
        write_enable <= 1'b0;
      end
      busy      <= busy_nxt;
      issue_err <= issue_err | (issue_valid && busy[issue_dest]);
    end
  end
endmodule

// File: tb/tb_register_writeback.sv
module tb_register_writeback;
  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid;
  logic [1:0] issue_dest;
  logic [3:0] busy;
  logic       issue_err;
  logic       alu_valid, alu_ready;
  logic [1:0] alu_dest;
  logic [7:0] alu_data;
  logic       mem_valid, mem_ready;
  logic [1:0] mem_dest;
  logic [7:0] mem_data;
  logic       hold;
  logic       write_enable;
  logic [1:0] dest_reg;
  logic [7:0] write_data;
  logic [1:0] q_count;

  int n_checks = 0;
  int n_fail   = 0;

  register_writeback #(.DATA_W(8), .ADDR_W(2), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_dest(issue_dest),
    .busy(busy), .issue_err(issue_err),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
    .hold(hold),
    .write_enable(write_enable), .dest_reg(dest_reg), .write_data(write_data),
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wp(input string tag, input logic we, input logic [1:0] d,
                        input logic [7:0] v, input logic [1:0] q);
    chk({tag, ".we"}, 32'(write_enable), 32'(we));
    if (we) begin
      chk({tag, ".dest"}, 32'(dest_reg), 32'(d));
      chk({tag, ".data"}, 32'(write_data), 32'(v));
    end
    chk({tag, ".q"}, 32'(q_count), 32'(q));
  endtask

  initial begin
    reset = 1'b0; issue_valid = 0; issue_dest = 0; hold = 0;
    alu_valid = 0; alu_dest = 0; alu_data = 0;
    mem_valid = 0; mem_dest = 0; mem_data = 0;
    #12;
    // reset state
    chk("rst.we", 32'(write_enable), 0);
    chk("rst.dest", 32'(dest_reg), 0);
    chk("rst.data", 32'(write_data), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.err", 32'(issue_err), 0);
    chk("rst.q", 32'(q_count), 0);
    chk("rst.mem_ready", 32'(mem_ready), 0);
    reset = 1'b1;
    step();
    chk("idle.mem_ready", 32'(mem_ready), 1);
    chk("idle.alu_ready", 32'(alu_ready), 1);

    // single ALU result, bypass path
    alu_valid = 1; alu_dest = 2; alu_data = 8'hA5;
    #1 chk("t1.alu_ready", 32'(alu_ready), 1);
    step(); alu_valid = 0;
    chk_wp("t1.w", 1, 2, 8'hA5, 0);
    step();
    chk_wp("t1.idle", 0, 0, 0, 0);
    chk("t1.hold_dest", 32'(dest_reg), 2);

    // mem priority
    mem_valid = 1; mem_dest = 1; mem_data = 8'h11;
    alu_valid = 1; alu_dest = 3; alu_data = 8'h33;
    #1 chk("t2.alu_ready", 32'(alu_ready), 0);
    chk("t2.mem_ready", 32'(mem_ready), 1);
    step(); mem_valid = 0;
    chk_wp("t2.w1", 1, 1, 8'h11, 0);
    #1 chk("t2.alu_ready2", 32'(alu_ready), 1);
    step(); alu_valid = 0;
    chk_wp("t2.w2", 1, 3, 8'h33, 0);
    step();
    chk_wp("t2.idle", 0, 0, 0, 0);

    // hold fills the queue
    hold = 1; alu_valid = 1; alu_dest = 0; alu_data = 8'h01;
    step();
    chk_wp("t3.h1", 0, 0, 0, 1);
    alu_dest = 1; alu_data = 8'h02;
    step();
    chk_wp("t3.h2", 0, 0, 0, 2);
    chk("t3.alu_ready", 32'(alu_ready), 0);
    chk("t3.mem_ready", 32'(mem_ready), 0);
    alu_dest = 2; alu_data = 8'h03;
    step();
    chk_wp("t3.h3", 0, 0, 0, 2);
    hold = 0;
    step();
    chk_wp("t3.d1", 1, 0, 8'h01, 1);
    chk("t3.alu_ready2", 32'(alu_ready), 1);
    step(); alu_valid = 0;
    chk_wp("t3.d2", 1, 1, 8'h02, 1);
    step();
    chk_wp("t3.d3", 1, 2, 8'h03, 0);
    step();
    chk_wp("t3.idle", 0, 0, 0, 0);

    // scoreboard set/clear
    issue_valid = 1; issue_dest = 0;
    step(); issue_valid = 0;
    chk("t4.busy_set", 32'(busy), 4'b0001);
    alu_valid = 1; alu_dest = 0; alu_data = 8'h44;
    step(); alu_valid = 0;
    chk("t4.busy_pending", 32'(busy), 4'b0001);
    step();
    chk("t4.busy_clr", 32'(busy), 4'b0000);
    // issue on the same edge as a write to reg0: set wins
    alu_valid = 1; alu_dest = 0; alu_data = 8'h55;
    step(); alu_valid = 0;
    chk_wp("t4.w", 1, 0, 8'h55, 0);
    issue_valid = 1; issue_dest = 0;
    step(); issue_valid = 0;
    chk("t4.set_wins", 32'(busy), 4'b0001);
    chk("t4.err", 32'(issue_err), 0);
    alu_valid = 1; alu_dest = 0; alu_data = 8'h66;
    step(); alu_valid = 0;
    step();
    chk("t4.busy_clr2", 32'(busy), 4'b0000);

    // double issue -> sticky error
    issue_valid = 1; issue_dest = 2;
    step();
    chk("t5.busy", 32'(busy), 4'b0100);
    chk("t5.err0", 32'(issue_err), 0);
    step(); issue_valid = 0;
    chk("t5.busy2", 32'(busy), 4'b0100);
    chk("t5.err1", 32'(issue_err), 1);
    alu_valid = 1; alu_dest = 2; alu_data = 8'h77;
    step(); alu_valid = 0;
    step();
    chk("t5.busy_clr", 32'(busy), 4'b0000);
    chk("t5.err_sticky", 32'(issue_err), 1);

    // async reset mid-operation
    issue_valid = 1; issue_dest = 3;
    hold = 1; alu_valid = 1; alu_dest = 1; alu_data = 8'h88;
    step(); issue_valid = 0;
    alu_data = 8'h99;
    step(); alu_valid = 0; hold = 0;
    chk_wp("t6.full", 0, 0, 0, 2);
    step();
    chk_wp("t6.pre", 1, 1, 8'h88, 1);
    chk("t6.busy_pre", 32'(busy), 4'b1000);
    #2 reset = 1'b0;
    #1;
    chk("t6.we", 32'(write_enable), 0);
    chk("t6.q", 32'(q_count), 0);
    chk("t6.busy", 32'(busy), 0);
    chk("t6.err", 32'(issue_err), 0);
    chk("t6.data", 32'(write_data), 0);
    #2 reset = 1'b1;
    step();
    chk_wp("t6.post1", 0, 0, 0, 0);
    step();
    chk_wp("t6.post2", 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
